// File: rtl/bcd_score_formatter.sv
// Binary score to 8-digit BCD with a leading-zero blank mask, using sequential double-dabble.
// Latency: WIDTH+2 edges, counting both the start-accept edge and the edge that raises done (29 at WIDTH=27).
// Backpressure: none; start is sampled only while idle, and start or value changes while busy are dropped.
//
// Ports:
//   clock, reset_L         rising-edge clock, async active-low reset
//   start, value           conversion request and the binary score, captured together
//   display_on             0 forces every digit blank (registered, one cycle of lag)
//   busy, done             busy from accept to result load; done pulses once per result
//   overflow               last converted value was clamped to 99_999_999
//   BCD7..BCD0             result digits, BCD7 most significant, updated only all at once
//   blank_mask             bit i blanks digit i on the downstream 7-segment driver
module bcd_score_formatter #(
  parameter int WIDTH      = 27,
  parameter bit LEAD_BLANK = 1'b1
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             display_on,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       BCD7,
  output logic [3:0]       BCD6,
  output logic [3:0]       BCD5,
  output logic [3:0]       BCD4,
  output logic [3:0]       BCD3,
  output logic [3:0]       BCD2,
  output logic [3:0]       BCD1,
  output logic [3:0]       BCD0,
  output logic [7:0]       blank_mask
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sat_q, sat_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      bcd_q, bcd_d;
  logic [7:0]       lead_q, lead_d;
  logic [7:0]       blank_q, blank_d;

  logic             value_ovf;
  logic [WIDTH-1:0] value_sat;
  logic [31:0]      acc_adj;
  logic [31+WIDTH:0] shift_v;
  logic [7:0]       lead_new;
  logic             all_zero;

  // Only a 27-bit or wider input can exceed eight decimal digits.
  if (WIDTH >= 27) begin : g_sat
    localparam logic [WIDTH-1:0] MAX_SCORE = WIDTH'(99_999_999);
    assign value_ovf = (value > MAX_SCORE);
    assign value_sat = value_ovf ? MAX_SCORE : value;
  end else begin : g_nosat
    assign value_ovf = 1'b0;
    assign value_sat = value;
  end

  // Double-dabble correction: any nibble >= 5 gets +3 so the following
  // left shift carries correctly into the next decimal digit.
  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < 8; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // One shift moves the top binary bit into the BCD accumulator LSB.
  assign shift_v = {acc_adj, sat_q} << 1;

  // Leading-zero mask from the finished accumulator. Digit 0 is never
  // blanked so a zero score still shows a single "0".
  always_comb begin
    lead_new = 8'h00;
    all_zero = 1'b1;
    if (LEAD_BLANK) begin
      for (int i = 7; i >= 1; i--) begin
        if (acc_q[4*i +: 4] != 4'd0) begin
          all_zero = 1'b0;
        end
        lead_new[i] = all_zero;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sat_d      = sat_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    bcd_d      = bcd_q;
    lead_d     = lead_q;
    // The display blank follows the stored lead mask, so it trails both
    // display_on and a fresh result by one cycle.
    blank_d    = display_on ? lead_q : 8'hFF;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sat_d      = value_sat;
          ovf_pend_d = value_ovf;
          acc_d      = 32'd0;
          cnt_d      = CNT_W'(WIDTH);
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = shift_v[31+WIDTH -: 32];
        sat_d = shift_v[WIDTH-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        // cnt_q == 1 marks the last of WIDTH shifts.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bcd_d      = acc_q;
        overflow_d = ovf_pend_q;
        lead_d     = lead_new;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_IDLE;
      sat_q      <= '0;
      acc_q      <= 32'd0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bcd_q      <= 32'd0;
      lead_q     <= 8'hFE;
      blank_q    <= 8'hFF;
    end else begin
      state_q    <= state_d;
      sat_q      <= sat_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      bcd_q      <= bcd_d;
      lead_q     <= lead_d;
      blank_q    <= blank_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign BCD7       = bcd_q[31:28];
  assign BCD6       = bcd_q[27:24];
  assign BCD5       = bcd_q[23:20];
  assign BCD4       = bcd_q[19:16];
  assign BCD3       = bcd_q[15:12];
  assign BCD2       = bcd_q[11:8];
  assign BCD1       = bcd_q[7:4];
  assign BCD0       = bcd_q[3:0];
  assign blank_mask = blank_q;

endmodule

// File: tb/tb_bcd_score_formatter.sv
// Bench for bcd_score_formatter: expected results are queued at start-accept and compared at done.
// Latency: done is expected WIDTH+1 edges after the accept edge, i.e. WIDTH+2 edges counting both.
// Backpressure: none; start pulses while busy must be dropped.
module tb_bcd_score_formatter;

  localparam int W = 27;

  typedef struct packed {
    logic [31:0] bcd;
    logic        ovf;
    logic [7:0]  mask;
  } exp_t;

  logic         clock;
  logic         reset_L;
  logic         start;
  logic [W-1:0] value;
  logic         display_on;

  logic         busy1, done1, ovf1;
  wire  [31:0]  bcd1;
  logic [7:0]   bm1;
  logic         busy0, done0, ovf0;
  wire  [31:0]  bcd0;
  logic [7:0]   bm0;

  int   checks;
  int   failures;
  exp_t exp_q[$];

  bcd_score_formatter #(.WIDTH(W), .LEAD_BLANK(1'b1)) dut (
    .clock(clock), .reset_L(reset_L), .start(start), .value(value),
    .display_on(display_on), .busy(busy1), .done(done1), .overflow(ovf1),
    .BCD7(bcd1[31:28]), .BCD6(bcd1[27:24]), .BCD5(bcd1[23:20]), .BCD4(bcd1[19:16]),
    .BCD3(bcd1[15:12]), .BCD2(bcd1[11:8]), .BCD1(bcd1[7:4]), .BCD0(bcd1[3:0]),
    .blank_mask(bm1)
  );

  bcd_score_formatter #(.WIDTH(W), .LEAD_BLANK(1'b0)) dut_nb (
    .clock(clock), .reset_L(reset_L), .start(start), .value(value),
    .display_on(display_on), .busy(busy0), .done(done0), .overflow(ovf0),
    .BCD7(bcd0[31:28]), .BCD6(bcd0[27:24]), .BCD5(bcd0[23:20]), .BCD4(bcd0[19:16]),
    .BCD3(bcd0[15:12]), .BCD2(bcd0[11:8]), .BCD1(bcd0[7:4]), .BCD0(bcd0[3:0]),
    .blank_mask(bm0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Decimal reference by division, with clamping and leading-zero mask.
  function automatic exp_t model(input logic [W-1:0] v);
    exp_t        e;
    int unsigned s;
    int unsigned p;
    bit          all0;
    e    = '0;
    s    = (v > 27'd99_999_999) ? 99_999_999 : int'(v);
    e.ovf = (v > 27'd99_999_999);
    p    = 1;
    for (int i = 0; i < 8; i++) begin
      e.bcd[4*i +: 4] = 4'((s / p) % 10);
      p = p * 10;
    end
    all0 = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (e.bcd[4*i +: 4] != 4'd0) all0 = 1'b0;
      e.mask[i] = all0;
    end
    return e;
  endfunction

  // Drives one start pulse, queues the expectation, and waits (bounded) for done.
  // Returns edges from accept to done (-1 on timeout) and cycles busy was seen high.
  task automatic do_convert(input logic [W-1:0] v, output int lat, output int bcyc);
    @(negedge clock);
    value = v;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    exp_q.push_back(model(v));
    lat  = -1;
    bcyc = 0;
    for (int n = 0; n < 80; n++) begin
      if (n > 0) @(negedge clock);
      if (busy1) bcyc++;
      if (done1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() == 0) e = '0;
    else e = exp_q.pop_front();
  endtask

  task automatic test_reset;
    reset_L = 1'b0; start = 1'b0; value = '0; display_on = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done1); end
    checks++; if (ovf1 !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf1); end
    checks++; if (bcd1 !== 32'h0) begin failures++; $display("FAIL reset_bcd: got %h want 00000000", bcd1); end
    checks++; if (bm1 !== 8'hFF) begin failures++; $display("FAIL reset_blank: got %h want ff", bm1); end
    reset_L = 1'b1;
    @(negedge clock);
    checks++; if (bm1 !== 8'hFE) begin failures++; $display("FAIL reset_lead: got %h want fe", bm1); end
  endtask

  task automatic test_zero;
    int lat, bcyc; exp_t e;
    do_convert('0, lat, bcyc);
    pop_exp(e);
    checks++; if (lat !== W + 1) begin failures++; $display("FAIL zero_latency: got %0d want %0d", lat, W + 1); end
    checks++; if (bcd1 !== e.bcd) begin failures++; $display("FAIL zero_bcd: got %h want %h", bcd1, e.bcd); end
    checks++; if (ovf1 !== 1'b0) begin failures++; $display("FAIL zero_ovf: got %b want 0", ovf1); end
    @(negedge clock);
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL zero_done_pulse: got %b want 0", done1); end
    checks++; if (bm1 !== 8'hFE) begin failures++; $display("FAIL zero_blank: got %h want fe", bm1); end
  endtask

  task automatic test_digits;
    int lat, bcyc; exp_t e;
    do_convert(27'd12345, lat, bcyc);
    pop_exp(e);
    checks++; if (bcyc !== W + 1) begin failures++; $display("FAIL d12345_busy_cycles: got %0d want %0d", bcyc, W + 1); end
    checks++; if (bcd1 !== 32'h0001_2345) begin failures++; $display("FAIL d12345_bcd: got %h want 00012345", bcd1); end
    checks++; if (bcd1 !== e.bcd) begin failures++; $display("FAIL d12345_model: got %h want %h", bcd1, e.bcd); end
    @(negedge clock);
    checks++; if (bm1 !== 8'hE0) begin failures++; $display("FAIL d12345_blank: got %h want e0", bm1); end
  endtask

  task automatic test_saturate;
    int lat, bcyc; exp_t e;
    logic [W-1:0] vals [2];
    vals[0] = 27'd99_999_999;
    vals[1] = 27'd100_000_000;
    for (int k = 0; k < 2; k++) begin
      do_convert(vals[k], lat, bcyc);
      pop_exp(e);
      checks++; if (bcd1 !== 32'h9999_9999) begin failures++; $display("FAIL sat%0d_bcd: got %h want 99999999", k, bcd1); end
      checks++; if (ovf1 !== e.ovf) begin failures++; $display("FAIL sat%0d_ovf: got %b want %b", k, ovf1, e.ovf); end
      @(negedge clock);
      checks++; if (bm1 !== 8'h00) begin failures++; $display("FAIL sat%0d_blank: got %h want 00", k, bm1); end
    end
  endtask

  task automatic test_ignore_busy;
    int dones; logic [31:0] got; exp_t e;
    @(negedge clock);
    value = 27'd4321; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    exp_q.push_back(model(27'd4321));
    dones = 0; got = '0;
    for (int n = 0; n < 60; n++) begin
      if (n > 0) @(negedge clock);
      if (n == 4) begin start = 1'b1; value = 27'd7; end
      else if (n == 5) start = 1'b0;
      if (done1) begin dones++; got = bcd1; end
    end
    pop_exp(e);
    checks++; if (dones !== 1) begin failures++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    checks++; if (got !== e.bcd) begin failures++; $display("FAIL ignore_bcd: got %h want %h", got, e.bcd); end
  endtask

  task automatic test_reset_mid;
    int dones, lat, bcyc; exp_t e;
    @(negedge clock);
    value = 27'd8765; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset_L = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy1); end
    checks++; if (bcd1 !== 32'h0) begin failures++; $display("FAIL abort_bcd: got %h want 00000000", bcd1); end
    checks++; if (bm1 !== 8'hFF) begin failures++; $display("FAIL abort_blank: got %h want ff", bm1); end
    @(negedge clock);
    reset_L = 1'b1;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (done1) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    do_convert(27'd555, lat, bcyc);
    pop_exp(e);
    checks++; if (bcd1 !== e.bcd) begin failures++; $display("FAIL abort_next_bcd: got %h want %h", bcd1, e.bcd); end
    checks++; if (lat !== W + 1) begin failures++; $display("FAIL abort_next_latency: got %0d want %0d", lat, W + 1); end
  endtask

  task automatic test_display;
    int lat, bcyc; exp_t e;
    do_convert(27'd42, lat, bcyc);
    pop_exp(e);
    checks++; if (bcd1 !== e.bcd) begin failures++; $display("FAIL disp_bcd: got %h want %h", bcd1, e.bcd); end
    checks++; if (bcd0 !== e.bcd) begin failures++; $display("FAIL disp_bcd_nb: got %h want %h", bcd0, e.bcd); end
    @(negedge clock);
    checks++; if (bm1 !== e.mask) begin failures++; $display("FAIL disp_on_blank: got %h want %h", bm1, e.mask); end
    display_on = 1'b0;
    @(negedge clock);
    checks++; if (bm1 !== 8'hFF) begin failures++; $display("FAIL disp_off_blank: got %h want ff", bm1); end
    checks++; if (bm0 !== 8'hFF) begin failures++; $display("FAIL disp_off_blank_nb: got %h want ff", bm0); end
    display_on = 1'b1;
    @(negedge clock);
    checks++; if (bm1 !== 8'hFC) begin failures++; $display("FAIL disp_back_blank: got %h want fc", bm1); end
    checks++; if (bm0 !== 8'h00) begin failures++; $display("FAIL disp_back_blank_nb: got %h want 00", bm0); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2; exp_t e; logic busy_gap, busy_re;
    @(negedge clock);
    value = 27'd31_415_926; start = 1'b1;
    @(negedge clock);
    exp_q.push_back(model(27'd31_415_926));
    lat1 = -1; lat2 = -1; busy_gap = 1'b1; busy_re = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (n > 0) @(negedge clock);
      if (n == 20) value = 27'd2_718;
      if (done1) begin
        lat1 = n;
        busy_gap = busy1;
        pop_exp(e);
        checks++; if (bcd1 !== e.bcd) begin failures++; $display("FAIL b2b_first_bcd: got %h want %h", bcd1, e.bcd); end
        break;
      end
    end
    @(negedge clock);
    busy_re = busy1;
    start = 1'b0;
    exp_q.push_back(model(27'd2_718));
    for (int n = 0; n < 80; n++) begin
      if (n > 0) @(negedge clock);
      if (done1) begin lat2 = n; break; end
    end
    pop_exp(e);
    checks++; if (lat1 !== W + 1) begin failures++; $display("FAIL b2b_first_latency: got %0d want %0d", lat1, W + 1); end
    checks++; if (busy_gap !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: busy %b want 0", busy_gap); end
    checks++; if (busy_re !== 1'b1) begin failures++; $display("FAIL b2b_retrigger: busy %b want 1", busy_re); end
    checks++; if (lat2 !== W + 1) begin failures++; $display("FAIL b2b_second_latency: got %0d want %0d", lat2, W + 1); end
    checks++; if (bcd1 !== e.bcd) begin failures++; $display("FAIL b2b_second_bcd: got %h want %h", bcd1, e.bcd); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_zero;
    test_digits;
    test_saturate;
    test_ignore_busy;
    test_reset_mid;
    test_display;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
